meas_range_ctrl: RTL

//  Measurement sequencer and auto-ranger for the digital frequency meter. Drives one shared

---
 rtl/meas_range_ctrl_if.sv | 29 ++
 rtl/meas_range_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/meas_range_ctrl_if.sv
// Controller-to-datapath/display bus for the frequency meter range controller.
// The controller takes the master side; the datapath/display model takes the slave side.
interface meas_range_ctrl_if #(
   parameter int CW = 24
);
   logic          run;
   logic          cin_rise;
   logic [CW-1:0] cnt;
   logic          cnt_ovf;
   logic          clr;
   logic          gate;
   logic [1:0]    mode;
   logic          latch;
   logic          valid;
   logic [CW-1:0] result;
   logic [1:0]    res_mode;
   logic          over;
   logic          tmo;

   modport master (
      input  run, cin_rise, cnt, cnt_ovf,
      output clr, gate, mode, latch, valid, result, res_mode, over, tmo
   );

   modport slave (
      output run, cin_rise, cnt, cnt_ovf,
      input  clr, gate, mode, latch, valid, result, res_mode, over, tmo
   );
endinterface

// File: rtl/meas_range_ctrl.sv
// Measurement sequencer and auto-ranger: drives the shared gated counter through
// clr/gate/settle/latch and steps between PER, LONG and SHORT modes from each result.
module meas_range_ctrl #(
   parameter int CW         = 24,
   parameter int GATE_LONG  = 50_000_000,
   parameter int GATE_SHORT = 50_000,
   parameter int PER_TMO    = 500_000_000,
   parameter int SETTLE     = 4,
   parameter int HI_TH      = 999_999,
   parameter int LO_LONG    = 10,
   parameter int LO_SHORT   = 1000,
   parameter int PER_TH     = 100
) (
   input  logic             clk,
   input  logic             Rst,
   meas_range_ctrl_if.master io_bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_ARM, S_GATE, S_SETTLE, S_LATCH, S_DECIDE
   } state_t;

   typedef enum logic [1:0] {
      M_PER   = 2'd0,
      M_LONG  = 2'd1,
      M_SHORT = 2'd2
   } mode_t;

   // One shared timer covers gate length, PER timeout and settle delay.
   localparam int TMAX = (PER_TMO > GATE_LONG) ? PER_TMO : GATE_LONG;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0] L_LONG_END   = TW'(GATE_LONG - 1);
   localparam logic [TW-1:0] L_SHORT_END  = TW'(GATE_SHORT - 1);
   localparam logic [TW-1:0] L_TMO_END    = TW'(PER_TMO - 1);
   localparam logic [TW-1:0] L_SETTLE_END = TW'(SETTLE - 1);

   localparam logic [CW-1:0] L_HI_TH    = CW'(HI_TH);
   localparam logic [CW-1:0] L_LO_LONG  = CW'(LO_LONG);
   localparam logic [CW-1:0] L_LO_SHORT = CW'(LO_SHORT);
   localparam logic [CW-1:0] L_PER_TH   = CW'(PER_TH);

   state_t        r_state;
   mode_t         r_mode;
   mode_t         r_res_mode;
   logic [TW-1:0] r_timer;
   logic          r_clr;
   logic          r_gate;
   logic          r_latch;
   logic          r_valid;
   logic [CW-1:0] r_result;
   logic          r_over;
   logic          r_tmo;

   mode_t         w_next_mode;
   logic          w_over;
   logic          w_gate_end;
   logic          w_tmo_now;

   assign w_gate_end = (r_mode == M_LONG) ? (r_timer == L_LONG_END)
                                          : (r_timer == L_SHORT_END);

   // A cin_rise in the same cycle as the timeout wins: the edge is still usable.
   assign w_tmo_now = (r_timer == L_TMO_END) && !io_bus.cin_rise &&
                      ((r_state == S_ARM) || (r_state == S_GATE && r_mode == M_PER));

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      w_next_mode = r_mode;
      w_over      = 1'b0;
      case (r_mode)
         M_LONG: begin
            if (io_bus.cnt_ovf || io_bus.cnt > L_HI_TH) w_next_mode = M_SHORT;
            else if (io_bus.cnt < L_LO_LONG)            w_next_mode = M_PER;
         end
         M_SHORT: begin
            if (io_bus.cnt_ovf)                  w_over      = 1'b1;
            else if (io_bus.cnt < L_LO_SHORT)    w_next_mode = M_LONG;
         end
         M_PER: begin
            if (io_bus.cnt < L_PER_TH) w_next_mode = M_LONG;
         end
         default: w_next_mode = M_LONG;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // in this block sees the pre-edge values of the others.
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         r_state    <= S_IDLE;
         r_mode     <= M_LONG;
         r_res_mode <= M_LONG;
         r_timer    <= '0;
         r_clr      <= 1'b0;
         r_gate     <= 1'b0;
         r_latch    <= 1'b0;
         r_valid    <= 1'b0;
         r_result   <= '0;
         r_over     <= 1'b0;
         r_tmo      <= 1'b0;
      end else begin
         r_clr   <= 1'b0;
         r_latch <= 1'b0;
         r_valid <= 1'b0;
         if (!io_bus.run && r_state != S_DECIDE) begin
            r_state <= S_IDLE;
            r_gate  <= 1'b0;
         end else if (w_tmo_now) begin
            r_state    <= S_DECIDE;
            r_gate     <= 1'b0;
            r_valid    <= 1'b1;
            r_result   <= '0;
            r_res_mode <= r_mode;
            r_over     <= 1'b0;
            r_tmo      <= 1'b1;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_state <= S_CLR;
                  r_clr   <= 1'b1;
               end
               S_CLR: begin
                  r_timer <= '0;
                  if (r_mode == M_PER) begin
                     r_state <= S_ARM;
                  end else begin
                     r_state <= S_GATE;
                     r_gate  <= 1'b1;
                  end
               end
               S_ARM: begin
                  if (io_bus.cin_rise) begin
                     r_state <= S_GATE;
                     r_gate  <= 1'b1;
                     r_timer <= '0;
                  end else begin
                     r_timer <= r_timer + TW'(1);
                  end
               end
               S_GATE: begin
                  if ((r_mode == M_PER) ? io_bus.cin_rise : w_gate_end) begin
                     r_state <= S_SETTLE;
                     r_gate  <= 1'b0;
                     r_timer <= '0;
                  end else begin
                     r_timer <= r_timer + TW'(1);
                  end
               end
               S_SETTLE: begin
                  if (r_timer == L_SETTLE_END) begin
                     r_state <= S_LATCH;
                     r_latch <= 1'b1;
                  end else begin
                     r_timer <= r_timer + TW'(1);
                  end
               end
               S_LATCH: begin
                  r_state    <= S_DECIDE;
                  r_valid    <= 1'b1;
                  r_result   <= io_bus.cnt;
                  r_res_mode <= r_mode;
                  r_over     <= w_over;
                  r_tmo      <= 1'b0;
                  r_mode     <= w_next_mode;
               end
               S_DECIDE: begin
                  if (io_bus.run) begin
                     r_state <= S_CLR;
                     r_clr   <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign io_bus.clr      = r_clr;
   assign io_bus.gate     = r_gate;
   assign io_bus.mode     = r_mode;
   assign io_bus.latch    = r_latch;
   assign io_bus.valid    = r_valid;
   assign io_bus.result   = r_result;
   assign io_bus.res_mode = r_res_mode;
   assign io_bus.over     = r_over;
   assign io_bus.tmo      = r_tmo;

endmodule
